// File: rtl/ff_array_pkg.sv
// Shared definitions for the banked flip-flop array: default geometry and
// the flush controller state encoding.
package ff_array_pkg;

    localparam int DEF_S_INDEX  = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_REG_OUT  = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

endpackage

// File: rtl/ff_array_flush_ctrl.sv
// Flush sequencer: walks every set index once, one per cycle, and reports
// busy for the duration plus a single-cycle completion pulse.
module ff_array_flush_ctrl
    import ff_array_pkg::*;
#(
    parameter int S_INDEX = DEF_S_INDEX
) (
    input  logic               clk0,
    input  logic               rst0_n,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done,
    output logic               clr_en,
    output logic [S_INDEX-1:0] clr_idx
);

    localparam logic [S_INDEX-1:0] CNT_ONE = {{(S_INDEX-1){1'b0}}, 1'b1};

    flush_state_t       state, state_nxt;
    logic [S_INDEX-1:0] cnt, cnt_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    // State, counter and registered status outputs.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            busy       <= busy_nxt;
            flush_done <= done_nxt;
        end
    end

    // Next-state logic; a request seen while flushing is simply not acted on.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            FLUSH: begin
                busy_nxt = 1'b1;
                cnt_nxt  = cnt + CNT_ONE;
                if (cnt == '1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // busy is a register mirroring FLUSH, so it doubles as the clear strobe.
    assign clr_en  = busy;
    assign clr_idx = cnt;

endmodule

// File: rtl/ff_array_banked.sv
// Multi-way flip-flop array sharing one set index across all ways, with
// per-way/per-bit masked writes, optional registered read port and a
// sequential whole-array flush.
module ff_array_banked
    import ff_array_pkg::*;
#(
    parameter int S_INDEX  = DEF_S_INDEX,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int REG_OUT  = DEF_REG_OUT
) (
    input  logic                      clk0,
    input  logic                      rst0_n,
    input  logic                      csb0,
    input  logic                      web0,
    input  logic [S_INDEX-1:0]        addr0,
    input  logic [NUM_WAYS-1:0]       way_we0,
    input  logic [WIDTH-1:0]          wmask0,
    input  logic [WIDTH-1:0]          din0,
    output logic [NUM_WAYS*WIDTH-1:0] dout0,
    input  logic                      flush_req,
    output logic                      busy,
    output logic                      flush_done
);

    localparam int NUM_SETS = 2 ** S_INDEX;

    logic [WIDTH-1:0]         mem [NUM_WAYS][NUM_SETS];
    logic                     clr_en;
    logic [S_INDEX-1:0]       clr_idx;
    logic                     wr_acc;
    logic [NUM_WAYS*WIDTH-1:0] rd_comb;

    function automatic logic [WIDTH-1:0] merge_bits(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [WIDTH-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    ff_array_flush_ctrl #(
        .S_INDEX (S_INDEX)
    ) u_flush_ctrl (
        .clk0       (clk0),
        .rst0_n     (rst0_n),
        .flush_req  (flush_req),
        .busy       (busy),
        .flush_done (flush_done),
        .clr_en     (clr_en),
        .clr_idx    (clr_idx)
    );

    // A write is dropped while flushing and in the cycle a flush is accepted
    // (busy is low exactly when a flush_req would be accepted).
    assign wr_acc = !csb0 && !web0 && !busy && !flush_req;

    // Storage: flush clear and masked write are mutually exclusive via busy.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    mem[w][s] <= '0;
                end
            end
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (clr_en) begin
                    mem[w][clr_idx] <= '0;
                end else if (wr_acc && way_we0[w]) begin
                    mem[w][addr0] <= merge_bits(mem[w][addr0], din0, wmask0);
                end
            end
        end
    end

    // Current contents of every way at addr0.
    always_comb begin
        rd_comb = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            rd_comb[w*WIDTH +: WIDTH] = mem[w][addr0];
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [NUM_WAYS*WIDTH-1:0] rd_byp;
        logic [NUM_WAYS*WIDTH-1:0] dout_p1;

        // Write-first view: ways being written this cycle show merged data.
        always_comb begin
            rd_byp = rd_comb;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wr_acc && way_we0[w]) begin
                    rd_byp[w*WIDTH +: WIDTH] =
                        merge_bits(mem[w][addr0], din0, wmask0);
                end
            end
        end

        // Read register loads on chip select and holds otherwise.
        always_ff @(posedge clk0 or negedge rst0_n) begin
            if (!rst0_n) begin
                dout_p1 <= '0;
            end else if (!csb0) begin
                dout_p1 <= rd_byp;
            end
        end

        assign dout0 = dout_p1;
    end else begin : g_comb_out
        assign dout0 = rd_comb;
    end

endmodule

// File: doc/ff_array_banked.md
FF_ARRAY_BANKED -- requirements
Module: ff_array_banked

Interface
REQ-001 SHALL have parameter S_INDEX, default 4, meaning index width; NUM_SETS = 2**S_INDEX.
REQ-002 SHALL have parameter WIDTH, default 8, meaning entry width in bits.
REQ-003 SHALL have parameter NUM_WAYS, default 4, meaning number of parallel ways sharing one index.
REQ-004 SHALL have parameter REG_OUT, default 0, meaning 0 = combinational read, 1 = registered read.
REQ-005 SHALL have port clk0  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst0_n  input  1  meaning reset, asynchronous and active-low.
REQ-007 SHALL have port csb0  input  1  meaning chip select, active-low.
REQ-008 SHALL have port web0  input  1  meaning write enable, active-low.
REQ-009 SHALL have port addr0  input  S_INDEX  meaning set index for read and write.
REQ-010 SHALL have port way_we0  input  NUM_WAYS  meaning per-way write enable; any combination legal.
REQ-011 SHALL have port wmask0  input  WIDTH  meaning per-bit write mask, 1 = update bit.
REQ-012 SHALL have port din0  input  WIDTH  meaning write data, broadcast to all enabled ways.
REQ-013 SHALL have port dout0  output  NUM_WAYS*WIDTH  meaning read data; way i at bits [i*WIDTH +: WIDTH].
REQ-014 SHALL have port flush_req  input  1  meaning request to clear every entry of every way.
REQ-015 SHALL have port busy  output  1  meaning flush in progress; writes dropped.
REQ-016 SHALL have port flush_done  output  1  meaning one-cycle pulse at flush completion.

Function
REQ-017 Write SHALL be accepted when csb0=0, web0=0, busy=0, and no flush_req accepted this cycle.
REQ-018 Accepted write SHALL set, for each way i with way_we0[i]=1, entry[i][addr0] to (old AND NOT wmask0) OR (din0 AND wmask0) at the clock edge.
REQ-019 With REG_OUT=0, dout0 SHALL combinationally reflect entry[*][addr0]; in a write cycle it shows pre-write data, with new data visible after the edge.
REQ-020 With REG_OUT=1, dout0 SHALL load entry[*][addr0] at the edge when csb0=0 and hold otherwise; read latency 1 cycle.
REQ-021 With REG_OUT=1, read-during-write to the same index SHALL return the merged new data (write-first bypass).
REQ-022 Flush FSM SHALL have states IDLE and FLUSH plus a counter cnt of S_INDEX bits.
REQ-023 In IDLE, flush_req=1 SHALL move to FLUSH with cnt=0; busy=1 from the next cycle.
REQ-024 Any write presented in the same cycle as an accepted flush_req SHALL be dropped.
REQ-025 In FLUSH, each cycle SHALL clear entry[*][cnt] in all ways and increment cnt.
REQ-026 When cnt=NUM_SETS-1 in FLUSH, the last entry SHALL be cleared, the FSM SHALL return to IDLE, and flush_done SHALL be 1 for exactly the first IDLE cycle; busy SHALL be 1 for exactly NUM_SETS cycles.
REQ-027 flush_req in FLUSH SHALL be ignored, not queued.
REQ-028 flush_req in the cycle flush_done=1 SHALL be accepted (FSM is IDLE).
REQ-029 Reads during FLUSH SHALL be permitted and SHALL return current, partially cleared contents.
REQ-030 Every output SHALL be driven from registers or the array, except dout0 when REG_OUT=0.

Reset
REQ-031 rst0_n=0 SHALL immediately clear all entries to 0, dout0 to 0, state to IDLE, cnt to 0, busy to 0 and flush_done to 0.
REQ-032 Reset asserted mid-flush SHALL abort the flush; no flush_done pulse follows.
REQ-033 After release, the first edge with rst0_n=1 SHALL accept writes and flush_req normally.

Structure
REQ-034 Package ff_array_pkg SHALL hold the flush state enum (IDLE, FLUSH) and the default parameter constants.
REQ-035 The flush FSM and counter SHALL be a sub-module ff_array_flush_ctrl (inputs flush_req; outputs busy, flush_done, clr_en, clr_idx); the storage and merge logic SHALL stay in ff_array_banked.

Verification
REQ-036 Write addr0=3, way_we0=4'b0101, wmask0=8'hFF, din0=8'hA5 -> ways 0 and 2 read 8'hA5 at index 3; ways 1 and 3 read 8'h00.
REQ-037 Entry holds 8'hFF; write wmask0=8'h0F, din0=8'h30 -> entry reads 8'hF0.
REQ-038 REG_OUT=1: same-cycle write 8'h5A and read at index 7 -> dout0 way 0 = 8'h5A one cycle later.
REQ-039 Fill all 16 sets; pulse flush_req -> busy high 16 cycles; flush_done one pulse; all entries read 0; a write during busy leaves no effect.
REQ-040 flush_req and a write to index 2 in the same IDLE cycle -> write dropped; index 2 reads 0 after flush.
REQ-041 Assert rst0_n=0 at flush cycle 5 -> busy=0 and flush_done=0 immediately; no later flush_done pulse; all entries 0.
